pc_unit: RTL and testbench
==========================

# pc_unit

Program-counter and redirect stage sitting directly downstream of the branch comparator: it consumes the resolved branch decision (`br_taken`) plus the branch PC, immediate and ALU result, and produces the next fetch address. It owns the sequential PC, the taken-branch/jump redirect, and a bounded pipeline-flush window. It also detects misaligned targets and latches them. Fetch reads `pc`; decode/execute squash on `flush`.

## Interface

Parameters:
- `RESET_PC`, default 32'h0000_0000: PC loaded on reset. Must be 4-byte aligned.
- `FLUSH_CYCLES`, default 2: flush-window length in non-stalled cycles. Must be at least 1.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `stall`  in  1  hold the PC. Redirects are still accepted.
- `br_valid`  in  1  execute stage has a control-transfer instruction this cycle.
- `br_kind`  in  2  00 conditional branch, 01 jal, 10 jalr, 11 reserved (treated as 00).
- `br_taken`  in  1  branch comparator decision. Only meaningful when `br_kind`=00.
- `br_pc`  in  32  PC of the resolving instruction.
- `br_imm`  in  32  sign-extended immediate.
- `alu_out`  in  32  rs1+imm, used as the jalr target.
- `pc`  out  32  current fetch address.
- `pc_valid`  out  1  `pc` is a legal fetch address.
- `flush`  out  1  squash younger in-flight instructions.
- `misalign`  out  1  one-cycle pulse when a misaligned target is detected.
- `bad_target`  out  32  latched offending target.

## Operation

- State machine has three states: RUN, FLUSH and HALT.
- Redirect condition: `redirect = br_valid & ~flush & (br_kind==01 | br_kind==10 | br_taken)`.
- Target arithmetic:
  - Conditional branch and jal: `br_pc + br_imm`, 32-bit modular (wraps, no overflow flag).
  - jalr: `alu_out & ~32'h1`.
- Alignment check: there is no C extension, so a target with bit[1] set is misaligned.
- RUN:
  - Redirect with an aligned target: `pc` <= target, flush counter <= FLUSH_CYCLES, go to FLUSH.
  - Redirect with a misaligned target: `bad_target` <= target, `misalign` pulses, `pc` frozen, go to HALT.
  - Otherwise, if `stall`=0, `pc` <= `pc`+4. 32'hFFFF_FFFC wraps to 0.
  - Otherwise (`stall`=1), `pc` holds.
- FLUSH:
  - `flush`=1 throughout.
  - `pc` advances by 4 from the target when `stall`=0, and holds when `stall`=1.
  - The counter decrements only on `stall`=0 cycles.
  - When the counter reaches 0, go to RUN.
  - `br_valid` is ignored: those are wrong-path instructions.
- HALT:
  - `pc` frozen, `pc_valid`=0, `flush`=1.
  - All inputs except `rst` are ignored.
  - HALT is exited only by reset.
- Not-taken conditional branch: no effect. Normal increment/stall rules apply.
- Priority: `rst` > misaligned redirect > redirect > `stall` > increment.
- `stall` never blocks a redirect. A redirect taken during `stall`=1 still loads the target.

## Timing

- All outputs are registered. No combinational input-to-output paths.
- Reset values, visible on the cycle after the `rst` edge:
  - `pc`=RESET_PC
  - `pc_valid`=0
  - `flush`=0
  - `misalign`=0
  - `bad_target`=0
  - state=RUN
- `pc_valid` rises on the first edge with `rst`=0. `pc` does not increment on that edge; the first fetch is at RESET_PC.
- Redirect latency is one cycle. The redirect is sampled at edge E; `pc`=target and `flush`=1 are visible after E.
- Flush window: with no stalls, `flush` is high for exactly FLUSH_CYCLES cycles after E. Each stalled cycle extends the window by one.
- `misalign` is high for exactly one cycle after the detecting edge. `bad_target` holds until reset.
- Reset mid-FLUSH or mid-HALT: next cycle is RUN, with `pc`=RESET_PC and `flush`=0 (`pc_valid` follows the reset rule above).
- Back-to-back redirects: the second arrives while `flush`=1 and is dropped. It is the next redirect after `flush` falls that is honoured.

## Test plan

- Reset sequence: `rst`=1 for 2 cycles, then release, no stall. Required: `pc` sequence 0x0 held, then 0x0, 0x4, 0x8. `pc_valid` goes 0 to 1 on release. `flush`=0 throughout.
- Taken beq: `br_pc`=0x100, `br_imm`=0xFFFF_FFF0, `br_taken`=1. Required: next `pc`=0xF0, `flush` high 2 cycles, `pc` then 0xF4, 0xF8. Same stimulus with `br_taken`=0: `pc` simply continues +4 and `flush` stays 0.
- jalr: `alu_out`=0x2001, `br_kind`=10, asserted together with `stall`=1. Required: `pc`=0x2000 next cycle. Hold `stall`=1 for 3 cycles: `pc` stays 0x2000 and `flush` stays high until 2 unstalled cycles have elapsed.
- Misaligned jal: `br_pc`=0x40, `br_imm`=0x6. Required: `misalign` one-cycle pulse, `bad_target`=0x46, `pc_valid`=0, `pc` frozen. Any further `br_valid` ignored. Then `rst`: `pc`=RESET_PC and normal run resumes.
- Redirect during flush: a taken branch to 0x300, then a taken branch to 0x500 on the next cycle. Required: `pc` goes to 0x300 and stays on that path; the 0x500 redirect is dropped.
- Wrap-around: RESET_PC=0xFFFF_FFF8. Required: `pc` sequence 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0. A branch with `br_pc`=0xFFFF_FFFC and `br_imm`=0x8 targets 0x4.

Source files
------------

// File: rtl/pc_unit.sv
// Program counter and redirect stage: sequential fetch address, branch/jump redirect,
// a bounded flush window after each redirect, and a sticky halt on misaligned targets.
module pc_unit #(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall,
    input  logic        br_valid,
    input  logic [1:0]  br_kind,
    input  logic        br_taken,
    input  logic [31:0] br_pc,
    input  logic [31:0] br_imm,
    input  logic [31:0] alu_out,
    output logic [31:0] pc,
    output logic        pc_valid,
    output logic        flush,
    output logic        misalign,
    output logic [31:0] bad_target
);

    localparam int CW = $clog2(FLUSH_CYCLES + 1);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        FLUSH = 2'd1,
        HALT  = 2'd2
    } state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [31:0]   pc_nxt, bad_nxt, target;
    logic          valid_nxt, mis_nxt, redirect;

    // jalr drops bit 0 of its target; kind 11 behaves like a conditional branch.
    always_comb begin
        target   = (br_kind == 2'b10) ? (alu_out & ~32'h1) : (br_pc + br_imm);
        redirect = br_valid & ~flush & ((br_kind == 2'b01) | (br_kind == 2'b10) | br_taken);
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pc_nxt    = pc;
        bad_nxt   = bad_target;
        valid_nxt = pc_valid;
        mis_nxt   = 1'b0;
        case (state)
            RUN: begin
                if (redirect && target[1]) begin
                    state_nxt = HALT;
                    bad_nxt   = target;
                    mis_nxt   = 1'b1;
                    valid_nxt = 1'b0;
                end else if (redirect) begin
                    state_nxt = FLUSH;
                    pc_nxt    = target;
                    cnt_nxt   = CW'(FLUSH_CYCLES);
                    valid_nxt = 1'b1;
                end else begin
                    // The first edge out of reset only raises pc_valid; fetch starts at RESET_PC.
                    if (!stall && pc_valid) begin
                        pc_nxt = pc + 32'd4;
                    end
                    valid_nxt = 1'b1;
                end
            end
            FLUSH: begin
                if (!stall) begin
                    pc_nxt = pc + 32'd4;
                    if (cnt == CW'(1)) begin
                        state_nxt = RUN;
                    end else begin
                        cnt_nxt = cnt - CW'(1);
                    end
                end
            end
            HALT: begin
                valid_nxt = 1'b0;
            end
            default: begin
                state_nxt = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            cnt        <= '0;
            pc         <= RESET_PC;
            pc_valid   <= 1'b0;
            flush      <= 1'b0;
            misalign   <= 1'b0;
            bad_target <= 32'h0;
        end else begin
            state      <= state_nxt;
            cnt        <= cnt_nxt;
            pc         <= pc_nxt;
            pc_valid   <= valid_nxt;
            flush      <= (state_nxt != RUN);
            misalign   <= mis_nxt;
            bad_target <= bad_nxt;
        end
    end

endmodule

// File: tb/tb_pc_unit.sv
// Self-checking bench for pc_unit: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the fetch/redirect rules.
module tb_pc_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        br_valid = 1'b0;
    logic [1:0]  br_kind = 2'b00;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'h0;
    logic [31:0] br_imm = 32'h0;
    logic [31:0] alu_out = 32'h0;

    logic [31:0] pc, bad_target, pc2, bad_target2;
    logic        pc_valid, flush, misalign, pc_valid2, flush2, misalign2;

    int checks = 0;
    int errors = 0;

    // Behavioural model state for dut (RESET_PC=0, FLUSH_CYCLES=2).
    logic [31:0] m_pc, m_bad;
    bit          m_valid, m_halted, m_mis;
    int          m_flush_left;

    always #5 clk = ~clk;

    pc_unit dut (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_kind(br_kind),
        .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm), .alu_out(alu_out),
        .pc(pc), .pc_valid(pc_valid), .flush(flush), .misalign(misalign), .bad_target(bad_target)
    );

    pc_unit #(.RESET_PC(32'hFFFF_FFF8), .FLUSH_CYCLES(2)) dut_wrap (
        .clk(clk), .rst(rst), .stall(stall), .br_valid(br_valid), .br_kind(br_kind),
        .br_taken(br_taken), .br_pc(br_pc), .br_imm(br_imm), .alu_out(alu_out),
        .pc(pc2), .pc_valid(pc_valid2), .flush(flush2), .misalign(misalign2), .bad_target(bad_target2)
    );

    // One clock edge of the fetch rules, evaluated on the inputs present at the edge.
    task automatic model_step();
        logic [31:0] tgt;
        bit          in_flush, take;
        if (rst) begin
            m_pc = 32'h0; m_valid = 0; m_flush_left = 0; m_halted = 0; m_mis = 0; m_bad = 32'h0;
            return;
        end
        m_mis = 0;
        if (m_halted) return;
        in_flush = (m_flush_left > 0);
        take = br_valid && !in_flush && (br_kind == 2'd1 || br_kind == 2'd2 || br_taken);
        tgt = (br_kind == 2'd2) ? {alu_out[31:1], 1'b0} : br_pc + br_imm;
        if (take && tgt[1]) begin
            m_halted = 1; m_mis = 1; m_bad = tgt; m_valid = 0;
        end else if (take) begin
            m_pc = tgt; m_flush_left = 2; m_valid = 1;
        end else begin
            if (!stall && (m_valid || in_flush)) m_pc = m_pc + 32'd4;
            if (in_flush && !stall) m_flush_left = m_flush_left - 1;
            m_valid = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic idle_inputs();
        stall = 0; br_valid = 0; br_kind = 2'b00; br_taken = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1; tick(); tick();
        rst = 0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (pc !== 32'h0) begin errors++; $display("FAIL rst_pc got %h exp %h", pc, 32'h0); end
        checks++; if (pc_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", pc_valid); end
        checks++; if (flush !== 1'b0) begin errors++; $display("FAIL rst_flush got %b exp 0", flush); end
        checks++; if (misalign !== 1'b0 || bad_target !== 32'h0) begin errors++; $display("FAIL rst_mis got %b/%h exp 0/0", misalign, bad_target); end
        tick();
        checks++; if (pc !== 32'h0 || pc_valid !== 1'b1) begin errors++; $display("FAIL rel_first got %h/%b exp 0/1", pc, pc_valid); end
        tick();
        checks++; if (pc !== 32'h4 || flush !== 1'b0) begin errors++; $display("FAIL rel_second got %h/%b exp 4/0", pc, flush); end
        tick();
        checks++; if (pc !== 32'h8 || flush !== 1'b0) begin errors++; $display("FAIL rel_third got %h/%b exp 8/0", pc, flush); end
    endtask

    task automatic test_taken_beq();
        logic [31:0] p;
        br_valid = 1; br_kind = 2'b00; br_taken = 1; br_pc = 32'h100; br_imm = 32'hFFFF_FFF0;
        tick(); idle_inputs();
        checks++; if (pc !== 32'hF0 || flush !== 1'b1) begin errors++; $display("FAIL beq_target got %h/%b exp f0/1", pc, flush); end
        tick();
        checks++; if (pc !== 32'hF4 || flush !== 1'b1) begin errors++; $display("FAIL beq_flush2 got %h/%b exp f4/1", pc, flush); end
        tick();
        checks++; if (pc !== 32'hF8 || flush !== 1'b0) begin errors++; $display("FAIL beq_after got %h/%b exp f8/0", pc, flush); end
        p = 32'hF8;
        br_valid = 1; br_taken = 0; br_pc = 32'h100; br_imm = 32'hFFFF_FFF0;
        tick(); idle_inputs();
        checks++; if (pc !== p + 32'd4 || flush !== 1'b0) begin errors++; $display("FAIL beq_nt got %h/%b exp %h/0", pc, flush, p + 32'd4); end
    endtask

    task automatic test_jalr_stall();
        br_valid = 1; br_kind = 2'b10; alu_out = 32'h2001; stall = 1;
        tick(); br_valid = 0;
        checks++; if (pc !== 32'h2000 || flush !== 1'b1) begin errors++; $display("FAIL jalr_target got %h/%b exp 2000/1", pc, flush); end
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (pc !== 32'h2000 || flush !== 1'b1) begin errors++; $display("FAIL jalr_stall%0d got %h/%b exp 2000/1", i, pc, flush); end
        end
        stall = 0; tick();
        checks++; if (pc !== 32'h2004 || flush !== 1'b1) begin errors++; $display("FAIL jalr_run1 got %h/%b exp 2004/1", pc, flush); end
        tick();
        checks++; if (pc !== 32'h2008 || flush !== 1'b0) begin errors++; $display("FAIL jalr_run2 got %h/%b exp 2008/0", pc, flush); end
    endtask

    task automatic test_misalign();
        logic [31:0] p;
        p = m_pc;
        br_valid = 1; br_kind = 2'b01; br_pc = 32'h40; br_imm = 32'h6;
        tick();
        checks++; if (misalign !== 1'b1 || bad_target !== 32'h46) begin errors++; $display("FAIL mis_pulse got %b/%h exp 1/46", misalign, bad_target); end
        checks++; if (pc_valid !== 1'b0 || pc !== p || flush !== 1'b1) begin errors++; $display("FAIL mis_halt got %b/%h/%b exp 0/%h/1", pc_valid, pc, flush, p); end
        br_kind = 2'b10; alu_out = 32'h800;
        tick();
        br_kind = 2'b00; br_taken = 1; br_pc = 32'h500; br_imm = 32'h2;
        tick(); idle_inputs();
        checks++; if (misalign !== 1'b0 || bad_target !== 32'h46 || pc !== p || pc_valid !== 1'b0) begin
            errors++; $display("FAIL mis_hold got %b/%h/%h/%b exp 0/46/%h/0", misalign, bad_target, pc, pc_valid, p); end
        do_reset();
        checks++; if (pc !== 32'h0 || flush !== 1'b0 || bad_target !== 32'h0) begin errors++; $display("FAIL mis_rst got %h/%b/%h exp 0/0/0", pc, flush, bad_target); end
        tick(); tick();
        checks++; if (pc !== 32'h4 || pc_valid !== 1'b1) begin errors++; $display("FAIL mis_resume got %h/%b exp 4/1", pc, pc_valid); end
    endtask

    task automatic test_back_to_back();
        br_valid = 1; br_kind = 2'b00; br_taken = 1; br_pc = 32'h200; br_imm = 32'h100;
        tick();
        br_pc = 32'h204; br_imm = 32'h2FC;
        tick(); idle_inputs();
        checks++; if (pc !== 32'h304) begin errors++; $display("FAIL b2b_drop got %h exp 304", pc); end
        tick();
        checks++; if (pc !== 32'h308 || flush !== 1'b0) begin errors++; $display("FAIL b2b_after got %h/%b exp 308/0", pc, flush); end
    endtask

    task automatic test_wrap();
        do_reset();
        tick();
        checks++; if (pc2 !== 32'hFFFF_FFF8) begin errors++; $display("FAIL wrap_0 got %h exp fffffff8", pc2); end
        tick();
        checks++; if (pc2 !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_1 got %h exp fffffffc", pc2); end
        tick();
        checks++; if (pc2 !== 32'h0) begin errors++; $display("FAIL wrap_2 got %h exp 0", pc2); end
        br_valid = 1; br_kind = 2'b00; br_taken = 1; br_pc = 32'hFFFF_FFFC; br_imm = 32'h8;
        tick(); idle_inputs();
        checks++; if (pc2 !== 32'h4 || flush2 !== 1'b1) begin errors++; $display("FAIL wrap_br got %h/%b exp 4/1", pc2, flush2); end
    endtask

    task automatic test_random();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 40) == 0);
            stall    = ($urandom_range(0, 3) == 0);
            br_valid = ($urandom_range(0, 2) == 0);
            br_kind  = 2'($urandom_range(0, 3));
            br_taken = $urandom_range(0, 1) == 1;
            br_pc    = $urandom() & 32'hFFFF_FFFC;
            br_imm   = ($urandom() & 32'hFFFF_FFFC) | (($urandom_range(0, 9) == 0) ? 32'h2 : 32'h0);
            alu_out  = ($urandom() & 32'hFFFF_FFFC) | 32'($urandom_range(0, 1))
                       | (($urandom_range(0, 9) == 0) ? 32'h2 : 32'h0);
            tick();
            checks++; if (pc !== m_pc) begin errors++; $display("FAIL rnd_pc cyc %0d got %h exp %h", n, pc, m_pc); end
            checks++; if (pc_valid !== m_valid) begin errors++; $display("FAIL rnd_valid cyc %0d got %b exp %b", n, pc_valid, m_valid); end
            checks++; if (flush !== (m_flush_left > 0 || m_halted)) begin errors++; $display("FAIL rnd_flush cyc %0d got %b", n, flush); end
            checks++; if (misalign !== m_mis) begin errors++; $display("FAIL rnd_mis cyc %0d got %b exp %b", n, misalign, m_mis); end
            checks++; if (bad_target !== m_bad) begin errors++; $display("FAIL rnd_bad cyc %0d got %h exp %h", n, bad_target, m_bad); end
        end
        rst = 0; idle_inputs();
    endtask

    initial begin
        test_reset();
        test_taken_beq();
        test_jalr_stall();
        test_misalign();
        test_back_to_back();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
